// File: rtl/fsm_arb_pkg.sv
// fsm_arb_pkg: shared types, widths and the legal mode-transition table for fsm_req_arbiter.
package fsm_arb_pkg;
    localparam int MODE_W = 2;
    localparam int TGT_W  = 3;

    // Three bits so that out-of-range encodings exist and can be recovered from.
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        GRANT = 3'd1,
        RESP  = 3'd2,
        DWELL = 3'd3
    } ctrl_t;

    typedef logic [MODE_W-1:0] mode_t;

    // Self-transitions are deliberately not in the table; the top treats them as a separate no-op case.
    function automatic logic is_legal(mode_t from, mode_t to);
        return (from == 2'd0) ? (to != 2'd0) :
               (from == 2'd1) ? (to == 2'd0 || to == 2'd2) :
               (from == 2'd2) ? (to == 2'd0 || to == 2'd3) :
                                (to == 2'd0);
    endfunction
endpackage

// File: rtl/fsm_req_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker; first set request at or after rr_ptr, wrapping.
module rr_pick #(
    parameter int NREQ = 2,
    parameter int IW   = 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   rr_ptr,
    output logic [NREQ-1:0] pick,
    output logic [IW-1:0]   idx,
    output logic            valid
);
    logic [NREQ-1:0] rot;
    logic [IW:0]     sum;

    always_comb begin
        rot = NREQ'({req, req} >> rr_ptr);
        sum = '0;
        for (int k = NREQ - 1; k >= 0; k--)
            if (rot[k]) sum = {1'b0, rr_ptr} + (IW+1)'(k);
        idx = (sum >= (IW+1)'(NREQ)) ? IW'(sum - (IW+1)'(NREQ)) : sum[IW-1:0];
        valid = |req;
        pick = valid ? NREQ'(1) << idx : '0;
    end
endmodule

// File: rtl/fsm_req_arbiter.sv
// fsm_req_arbiter: round-robin arbitration of target-state requests onto a 2-bit mode FSM,
// applying legal transitions and rejecting illegal or out-of-range targets with err.
module fsm_req_arbiter
    import fsm_arb_pkg::*;
#(
    parameter int NREQ        = 2,
    parameter int HOLD_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req,
    input  logic [TGT_W*NREQ-1:0] req_state,
    output logic [NREQ-1:0]       grant,
    output logic                  ack,
    output logic                  err,
    output logic [MODE_W-1:0]     mode_state,
    output logic                  busy
);
    localparam int IW = (NREQ > 2) ? 2 : 1;
    localparam int CW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

    ctrl_t            ctrl, ctrl_n;
    logic [NREQ-1:0]  pick;
    logic [IW-1:0]    pick_idx, rr_ptr, owner_q;
    logic             pick_valid, owner_live, same, accept, apply, dwell_done, bad_enc;
    logic [TGT_W-1:0] tgt_q;
    logic [CW-1:0]    cnt;

    rr_pick #(.NREQ(NREQ), .IW(IW)) u_pick (
        .req    (req),
        .rr_ptr (rr_ptr),
        .pick   (pick),
        .idx    (pick_idx),
        .valid  (pick_valid)
    );

    assign owner_live = |(req & grant);
    assign same       = tgt_q[MODE_W-1:0] == mode_state;
    assign accept     = !tgt_q[TGT_W-1] && (same || is_legal(mode_state, tgt_q[MODE_W-1:0]));
    assign apply      = accept && !same;
    assign dwell_done = cnt == CW'(HOLD_CYCLES - 1);
    assign bad_enc    = !(ctrl inside {IDLE, GRANT, RESP, DWELL});

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) ctrl <= IDLE;
        else        ctrl <= ctrl_n;

    always_comb begin
        ctrl_n = IDLE;
        case (ctrl)
            IDLE:    ctrl_n = pick_valid ? GRANT : IDLE;
            GRANT:   ctrl_n = owner_live ? RESP : IDLE;
            RESP:    ctrl_n = apply ? DWELL : IDLE;
            DWELL:   ctrl_n = dwell_done ? IDLE : DWELL;
            default: ctrl_n = IDLE;
        endcase
    end

    always_comb begin
        ack  = ctrl == RESP && accept;
        err  = (ctrl == RESP && !accept) || bad_enc;
        busy = ctrl != IDLE;
    end

    // Grant is loaded only on IDLE->GRANT and held through RESP, so an abort or bad state clears it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant      <= '0;
            tgt_q      <= '0;
            owner_q    <= '0;
            rr_ptr     <= '0;
            mode_state <= '0;
            cnt        <= '0;
        end else begin
            grant <= (ctrl_n == GRANT) ? pick : (ctrl_n == RESP) ? grant : '0;
            cnt   <= (ctrl == DWELL) ? cnt + 1'b1 : '0;
            if (ctrl == IDLE && pick_valid) begin
                tgt_q   <= req_state[pick_idx*TGT_W +: TGT_W];
                owner_q <= pick_idx;
            end
            if (ctrl == RESP) begin
                rr_ptr <= (owner_q == IW'(NREQ - 1)) ? '0 : owner_q + 1'b1;
                if (apply) mode_state <= tgt_q[MODE_W-1:0];
            end
        end
    end
endmodule

// File: tb/tb_fsm_req_arbiter.sv
// tb_fsm_req_arbiter: directed stimulus with a scoreboard queue checked by an independent monitor.
module tb_fsm_req_arbiter;
    import fsm_arb_pkg::*;

    typedef struct {
        logic [1:0] grant;
        logic       ack;
        logic       err;
        logic [1:0] mode;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] req = '0;
    logic [5:0] req_state = '0;
    logic [1:0] grant;
    logic       ack, err, busy;
    logic [1:0] mode_state;

    exp_t sbq[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    bit   forcing = 1'b0;

    fsm_req_arbiter #(.NREQ(2), .HOLD_CYCLES(2)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (req),
        .req_state  (req_state),
        .grant      (grant),
        .ack        (ack),
        .err        (err),
        .mode_state (mode_state),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every ack/err pulse must match the oldest expectation; mode is checked one cycle later.
    initial begin
        exp_t       e;
        bit         pend = 1'b0;
        logic [1:0] pm = '0;
        forever begin
            @(negedge clk);
            if (pend) begin
                chk("sb_mode_after", mode_state, pm);
                pend = 1'b0;
            end
            if (!forcing && (ack || err)) begin
                if (sbq.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL sb_unexpected: got ack=%0b err=%0b grant=%0b, expected no pulse", ack, err, grant);
                end else begin
                    e = sbq.pop_front();
                    chk("sb_grant", grant, e.grant);
                    chk("sb_ack", ack, e.ack);
                    chk("sb_err", err, e.err);
                    pm = e.mode;
                    pend = 1'b1;
                end
            end
        end
    end

    task automatic push(logic [1:0] g, logic a, logic [1:0] m);
        sbq.push_back('{grant: g, ack: a, err: !a, mode: m});
    endtask

    task automatic wait_done(int i);
        bit ok = 1'b0;
        for (int c = 0; c < 30 && !ok; c++) begin
            @(negedge clk);
            if ((ack || err) && grant[i]) begin
                ok = 1'b1;
                req[i] = 1'b0;
            end
        end
        n_cmp++;
        if (!ok) begin
            n_bad++;
            $display("FAIL timeout_req%0d: got no response, expected ack or err", i);
        end
    endtask

    task automatic wait_idle();
        bit ok = 1'b0;
        for (int c = 0; c < 30 && !ok; c++) begin
            @(negedge clk);
            ok = !busy;
        end
        n_cmp++;
        if (!ok) begin
            n_bad++;
            $display("FAIL timeout_idle: got busy=1, expected 0");
        end
    endtask

    task automatic issue(int i, logic [2:0] tgt);
        @(posedge clk);
        #1;
        req_state[3*i +: 3] = tgt;
        req[i] = 1'b1;
    endtask

    // One full transaction; dw says whether a DWELL should follow the response.
    task automatic serve(int i, logic [2:0] tgt, logic a, logic [1:0] m, logic dw);
        issue(i, tgt);
        push(2'(1 << i), a, m);
        wait_done(i);
        @(negedge clk);
        chk("dwell_after_resp", busy, dw);
        wait_idle();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, expected bench end");
        $fatal(1);
    end

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_grant", grant, 0);
        chk("rst_ack", ack, 0);
        chk("rst_err", err, 0);
        chk("rst_mode", mode_state, 0);
        chk("rst_busy", busy, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Latency: req at N, grant N+1, ack N+2, mode N+3, two DWELL cycles
        issue(0, 3'd1);
        push(2'b01, 1'b1, 2'd1);
        @(negedge clk);
        chk("t1_grant_n", grant, 0);
        chk("t1_busy_n", busy, 0);
        @(negedge clk);
        chk("t1_grant_n1", grant, 2'b01);
        chk("t1_busy_n1", busy, 1);
        @(negedge clk);
        chk("t1_ack_n2", ack, 1);
        req[0] = 1'b0;
        @(negedge clk);
        chk("t1_busy_dwell1", busy, 1);
        chk("t1_grant_dwell", grant, 0);
        @(negedge clk);
        chk("t1_busy_dwell2", busy, 1);
        @(negedge clk);
        chk("t1_busy_idle", busy, 0);

        // Reach mode 3, reject 3->2, then accept 3->0
        serve(0, 3'd0, 1'b1, 2'd0, 1'b1);
        serve(0, 3'd3, 1'b1, 2'd3, 1'b1);
        serve(0, 3'd2, 1'b0, 2'd3, 1'b0);
        serve(0, 3'd0, 1'b1, 2'd0, 1'b1);

        // Out-of-range target and self-transition from requester 1; leaves rr_ptr at 0
        serve(1, 3'd5, 1'b0, 2'd0, 1'b0);
        serve(1, 3'd0, 1'b1, 2'd0, 1'b0);

        // Both requesters at once: req0 first, req1 granted right after DWELL
        @(posedge clk);
        #1;
        req_state = {3'd0, 3'd1};
        req = 2'b11;
        push(2'b01, 1'b1, 2'd1);
        push(2'b10, 1'b1, 2'd0);
        @(negedge clk);
        @(negedge clk);
        chk("t3_grant_first", grant, 2'b01);
        @(negedge clk);
        req[0] = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("t3_grant_gap", grant, 0);
        end
        @(negedge clk);
        chk("t3_grant_second", grant, 2'b10);
        wait_done(1);
        wait_idle();

        // Abort during GRANT: no pulse, back to IDLE, rr_ptr still 0
        issue(0, 3'd1);
        @(negedge clk);
        @(negedge clk);
        chk("t5_grant", grant, 2'b01);
        req[0] = 1'b0;
        @(negedge clk);
        chk("t5_abort_grant", grant, 0);
        chk("t5_abort_busy", busy, 0);
        chk("t5_abort_ack", ack, 0);
        chk("t5_abort_err", err, 0);
        @(negedge clk);
        chk("t5_mode", mode_state, 0);
        @(posedge clk);
        #1;
        req_state = {3'd0, 3'd2};
        req = 2'b11;
        push(2'b01, 1'b1, 2'd2);
        push(2'b10, 1'b1, 2'd0);
        wait_done(0);
        wait_done(1);
        wait_idle();

        // Reset asserted inside RESP discards the transaction
        serve(0, 3'd2, 1'b1, 2'd2, 1'b1);
        issue(0, 3'd0);
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("t6_rst_grant", grant, 0);
        chk("t6_rst_ack", ack, 0);
        chk("t6_rst_err", err, 0);
        chk("t6_rst_busy", busy, 0);
        chk("t6_rst_mode", mode_state, 0);
        req[0] = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("t6_post_mode", mode_state, 0);
        chk("t6_post_busy", busy, 0);

        // Bad controller encoding: one err, no grant, mode untouched, then IDLE
        serve(0, 3'd1, 1'b1, 2'd1, 1'b1);
        @(posedge clk);
        #1;
        forcing = 1'b1;
        force dut.ctrl = ctrl_t'(3'd5);
        @(negedge clk);
        chk("t6_bad_err", err, 1);
        chk("t6_bad_ack", ack, 0);
        chk("t6_bad_grant", grant, 0);
        #1 release dut.ctrl;
        @(negedge clk);
        chk("t6_bad_recover_err", err, 0);
        chk("t6_bad_recover_busy", busy, 0);
        chk("t6_bad_mode", mode_state, 1);
        forcing = 1'b0;

        repeat (2) @(negedge clk);
        chk("sb_drained", sbq.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
